prach_nco_mc: RTL and testbench
===============================

Name: prach_nco_mc

Overview:
Multi-channel, parametrised PRACH down-conversion NCO. It keeps one modulo phase accumulator per TDM channel, with a per-channel frequency control word (FCW) and start phase set through a config port. For each valid input sample it emits a cos/sin pair from a shared quarter-period-aligned sine LUT, with control delayed to match the data. It sits ahead of the PRACH mixer; its outputs align with the sample stream that drives din_dv/din_chn.

Parameters:
NUM_CHN, 4, number of TDM channels with independent accumulators (1..16)
CHN_WIDTH, 8, width of channel index ports
LUT_DEPTH, 1536, phase steps per 2π; must be a multiple of 4
PHASE_WIDTH, 11, accumulator width; must equal ceil(log2(LUT_DEPTH))
OUT_WIDTH, 16, output width; format fi(1, OUT_WIDTH, OUT_WIDTH-2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_chn  in  CHN_WIDTH  channel index for the config write
cfg_fcw  in  PHASE_WIDTH  phase increment per sample of that channel
cfg_phase0  in  PHASE_WIDTH  constant phase offset for that channel
cfg_err  out  1  one-cycle pulse when a config write is rejected
din_dv  in  1  input sample valid
din_chn  in  CHN_WIDTH  channel of the input sample
sync_in  in  1  frame sync; clears all accumulators
dout_cos  out  OUT_WIDTH  cos(2π·φ/LUT_DEPTH)·2^(OUT_WIDTH-2)
dout_sin  out  OUT_WIDTH  sin(2π·φ/LUT_DEPTH)·2^(OUT_WIDTH-2)
dout_chn  out  CHN_WIDTH  din_chn delayed
dout_dv  out  1  din_dv delayed
sync_out  out  1  sync_in delayed

Behaviour:
- Single clock clk. rst is synchronous, active-high. rst clears every accumulator, FCW, phase0 and pipeline register. All outputs read 0 on the cycle after rst is sampled high. rst asserted mid-stream drops all in-flight samples; no dout_dv is produced for them.
- Modular add: madd(a,b) = a+b if a+b < LUT_DEPTH, else a+b-LUT_DEPTH. Operands are always < LUT_DEPTH. The sum is computed at PHASE_WIDTH+1 bits.
- Sample phase: φ = madd(acc[c], phase0[c]), where acc[c] is the pre-update value.
  - sin index = φ.
  - cos index = madd(φ, LUT_DEPTH/4).
- Accumulator update, in priority order:
  1. sync_in=1: all acc <= 0. No increment this cycle, even if din_dv=1. The sample accepted this cycle still uses its pre-sync phase.
  2. din_dv=1 and din_chn < NUM_CHN: acc[din_chn] <= madd(acc[din_chn], fcw[din_chn]). Other channels hold.
  3. Otherwise: hold.
- Out-of-range channel (din_chn >= NUM_CHN): no accumulator changes. Pipeline still carries dv/chn, and dout_cos = dout_sin = 0.
- Config write: cfg_we=1 with cfg_chn < NUM_CHN, cfg_fcw < LUT_DEPTH and cfg_phase0 < LUT_DEPTH writes fcw/phase0 for that channel at the clock edge.
  - acc is not affected.
  - A sample of the same channel in the same cycle uses the old fcw and phase0.
  - Any violated condition leaves the registers untouched, and cfg_err=1 on the next cycle for exactly one cycle.
- LUT: entry i = round-half-away-from-zero(sin(2π·i/LUT_DEPTH)·2^(OUT_WIDTH-2)), with i in 0..LUT_DEPTH-1. It is a read-only ROM, initialised at elaboration, and both ports read it.
- Latency is exactly 4 cycles from din_dv/din_chn/sync_in to dout_cos/dout_sin/dout_chn/dout_dv/sync_out. Pipeline stages:
  - S1: φ register.
  - S2: sin/cos index registers, with the out-of-range flag.
  - S3: LUT read register.
  - S4: output register, with zero forcing.
- Throughput is one sample per cycle on any channel mix, with no bubbles. Outputs are registered; dout_cos/dout_sin hold their last value while dout_dv=0.

Test Plan:
1. Reset, then fcw[0]=0, phase0[0]=0, one din_dv on chn 0 at cycle t -> at t+4: dout_dv=1, dout_chn=0, dout_cos=16384, dout_sin=0. All outputs are 0 before t+4.
2. fcw[0]=419, din_dv on chn 0 every cycle -> phase sequence 0, 419, 838, 1257, 140 (wrap), 559. dout values match a golden LUT model bit-exactly.
3. phase0[1]=384, fcw[1]=0, samples on chn 1 -> dout_sin=16384, dout_cos=0 on every sample. A sample on chn 0 in between is unaffected.
4. Interleave chn 0/1/2/3 with fcw 1/2/3/4 for 8 rounds -> each channel's phase advances only on its own samples (chn 3 reaches 32). A write to fcw[2] mid-stream takes effect from the next chn-2 sample.
5. sync_in together with din_dv on chn 0 (acc[0]=838) -> that sample outputs phase 838, the next outputs phase 0. sync_out pulses exactly 4 cycles after sync_in.
6. cfg_fcw=1536 on chn 0, then cfg_chn=5 -> cfg_err pulses one cycle each and fcw[0] is unchanged. din_chn=5 -> dout_dv=1, dout_chn=5, dout_cos=dout_sin=0. Asserting rst mid-stream -> no further dout_dv.

Source files
------------

// File: rtl/prach_nco_mc.sv
// Multi-channel PRACH down-conversion NCO: per-channel modulo phase accumulators
// feeding a shared sine ROM through a 4-stage pipeline aligned with the sample stream.
module prach_nco_mc #(
    parameter int NUM_CHN     = 4,
    parameter int CHN_WIDTH   = 8,
    parameter int LUT_DEPTH   = 1536,
    parameter int PHASE_WIDTH = 11,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [CHN_WIDTH-1:0]   cfg_chn,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw,
    input  logic [PHASE_WIDTH-1:0] cfg_phase0,
    output logic                   cfg_err,
    input  logic                   din_dv,
    input  logic [CHN_WIDTH-1:0]   din_chn,
    input  logic                   sync_in,
    output logic [OUT_WIDTH-1:0]   dout_cos,
    output logic [OUT_WIDTH-1:0]   dout_sin,
    output logic [CHN_WIDTH-1:0]   dout_chn,
    output logic                   dout_dv,
    output logic                   sync_out
);
    localparam int                   IDX_W   = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int                   NSLOT   = 1 << IDX_W;
    localparam logic [PHASE_WIDTH:0] DEPTH   = (PHASE_WIDTH + 1)'(LUT_DEPTH);
    localparam logic [PHASE_WIDTH-1:0] QUARTER = PHASE_WIDTH'(LUT_DEPTH / 4);
    localparam real                  PI      = 3.14159265358979323846;
    localparam real                  SCALE   = 2.0 ** (OUT_WIDTH - 2);

    function automatic logic [PHASE_WIDTH-1:0] madd(input logic [PHASE_WIDTH-1:0] a,
                                                    input logic [PHASE_WIDTH-1:0] b);
        logic [PHASE_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= DEPTH) s = s - DEPTH;
        return s[PHASE_WIDTH-1:0];
    endfunction

    // Round half away from zero, evaluated once at elaboration.
    function automatic logic [OUT_WIDTH-1:0] lut_entry(input int i);
        real v;
        v = $sin(2.0 * PI * real'(i) / real'(LUT_DEPTH)) * SCALE;
        if (v >= 0.0) return OUT_WIDTH'($rtoi($floor(v + 0.5)));
        else          return OUT_WIDTH'(-$rtoi($floor(-v + 0.5)));
    endfunction

    logic [OUT_WIDTH-1:0] lut [LUT_DEPTH];
    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        assign lut[g] = lut_entry(g);
    end

    logic [PHASE_WIDTH-1:0] acc    [NSLOT];
    logic [PHASE_WIDTH-1:0] fcw    [NSLOT];
    logic [PHASE_WIDTH-1:0] phase0 [NSLOT];

    logic [IDX_W-1:0]       din_idx, cfg_idx;
    logic                   din_ok, cfg_ok;
    logic [PHASE_WIDTH-1:0] phi_c;

    always_comb begin
        din_idx = din_chn[IDX_W-1:0];
        cfg_idx = cfg_chn[IDX_W-1:0];
        din_ok  = 32'(din_chn) < 32'(NUM_CHN);
        cfg_ok  = (32'(cfg_chn) < 32'(NUM_CHN)) &&
                  ({1'b0, cfg_fcw} < DEPTH) && ({1'b0, cfg_phase0} < DEPTH);
        phi_c   = madd(acc[din_idx], phase0[din_idx]);
    end

    // Sync wins over increment; config writes never touch the accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                acc[i]    <= '0;
                fcw[i]    <= '0;
                phase0[i] <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            if (sync_in) begin
                for (int unsigned i = 0; i < NSLOT; i++) acc[i] <= '0;
            end else if (din_dv && din_ok) begin
                acc[din_idx] <= madd(acc[din_idx], fcw[din_idx]);
            end
            if (cfg_we && cfg_ok) begin
                fcw[cfg_idx]    <= cfg_fcw;
                phase0[cfg_idx] <= cfg_phase0;
            end
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    logic [PHASE_WIDTH-1:0] s1_phi;
    logic                   s1_dv, s1_oor, s1_sync;
    logic [CHN_WIDTH-1:0]   s1_chn;
    logic [PHASE_WIDTH-1:0] s2_sin_idx, s2_cos_idx;
    logic                   s2_dv, s2_oor, s2_sync;
    logic [CHN_WIDTH-1:0]   s2_chn;
    logic [OUT_WIDTH-1:0]   s3_sin, s3_cos;
    logic                   s3_dv, s3_oor, s3_sync;
    logic [CHN_WIDTH-1:0]   s3_chn;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_phi     <= '0; s1_dv <= 1'b0; s1_oor <= 1'b0; s1_sync <= 1'b0; s1_chn <= '0;
            s2_sin_idx <= '0; s2_cos_idx <= '0;
            s2_dv      <= 1'b0; s2_oor <= 1'b0; s2_sync <= 1'b0; s2_chn <= '0;
            s3_sin     <= '0; s3_cos <= '0;
            s3_dv      <= 1'b0; s3_oor <= 1'b0; s3_sync <= 1'b0; s3_chn <= '0;
            dout_cos   <= '0; dout_sin <= '0; dout_chn <= '0;
            dout_dv    <= 1'b0; sync_out <= 1'b0;
        end else begin
            s1_phi     <= din_ok ? phi_c : '0;
            s1_dv      <= din_dv;
            s1_oor     <= !din_ok;
            s1_sync    <= sync_in;
            s1_chn     <= din_chn;

            s2_sin_idx <= s1_phi;
            s2_cos_idx <= madd(s1_phi, QUARTER);
            s2_dv      <= s1_dv;
            s2_oor     <= s1_oor;
            s2_sync    <= s1_sync;
            s2_chn     <= s1_chn;

            s3_sin     <= lut[s2_sin_idx];
            s3_cos     <= lut[s2_cos_idx];
            s3_dv      <= s2_dv;
            s3_oor     <= s2_oor;
            s3_sync    <= s2_sync;
            s3_chn     <= s2_chn;

            dout_dv    <= s3_dv;
            dout_chn   <= s3_chn;
            sync_out   <= s3_sync;
            if (s3_dv) begin
                dout_cos <= s3_oor ? '0 : s3_cos;
                dout_sin <= s3_oor ? '0 : s3_sin;
            end
        end
    end
endmodule

// File: tb/tb_prach_nco_mc.sv
// Directed + random bench for prach_nco_mc against a queue-based behavioural model.
module tb_prach_nco_mc;
    localparam int  NUM_CHN     = 4;
    localparam int  CHN_WIDTH   = 8;
    localparam int  LUT_DEPTH   = 1536;
    localparam int  PHASE_WIDTH = 11;
    localparam int  OUT_WIDTH   = 16;
    localparam real PI          = 3.14159265358979323846;
    localparam real SCALE       = 16384.0;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cfg_we = 1'b0;
    logic [CHN_WIDTH-1:0]   cfg_chn = '0;
    logic [PHASE_WIDTH-1:0] cfg_fcw = '0;
    logic [PHASE_WIDTH-1:0] cfg_phase0 = '0;
    logic                   cfg_err;
    logic                   din_dv = 1'b0;
    logic [CHN_WIDTH-1:0]   din_chn = '0;
    logic                   sync_in = 1'b0;
    logic [OUT_WIDTH-1:0]   dout_cos, dout_sin;
    logic [CHN_WIDTH-1:0]   dout_chn;
    logic                   dout_dv, sync_out;

    always #5 clk = ~clk;

    prach_nco_mc #(
        .NUM_CHN(NUM_CHN), .CHN_WIDTH(CHN_WIDTH), .LUT_DEPTH(LUT_DEPTH),
        .PHASE_WIDTH(PHASE_WIDTH), .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_chn(cfg_chn), .cfg_fcw(cfg_fcw),
        .cfg_phase0(cfg_phase0), .cfg_err(cfg_err), .din_dv(din_dv), .din_chn(din_chn),
        .sync_in(sync_in), .dout_cos(dout_cos), .dout_sin(dout_sin), .dout_chn(dout_chn),
        .dout_dv(dout_dv), .sync_out(sync_out)
    );

    typedef struct { bit dv; int chn; int cosv; int sinv; bit sync; } exp_t;
    exp_t pipe[$];
    int   acc_m [NUM_CHN];
    int   fcw_m [NUM_CHN];
    int   ph0_m [NUM_CHN];
    int   last_cos, last_sin;
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic int golden(input int idx);
        real v;
        v = $sin(2.0 * PI * real'(idx) / real'(LUT_DEPTH)) * SCALE;
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        else          return -$rtoi($floor(-v + 0.5));
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input exp_t e, input bit err_exp);
        check("dout_dv",  32'(dout_dv),  32'(e.dv));
        check("dout_chn", 32'(dout_chn), e.chn);
        check("dout_cos", 32'($signed(dout_cos)), last_cos);
        check("dout_sin", 32'($signed(dout_sin)), last_sin);
        check("sync_out", 32'(sync_out), 32'(e.sync));
        check("cfg_err",  32'(cfg_err),  32'(err_exp));
    endtask

    task automatic model_reset();
        exp_t idle;
        idle = '{dv: 1'b0, chn: 0, cosv: 0, sinv: 0, sync: 1'b0};
        for (int i = 0; i < NUM_CHN; i++) begin
            acc_m[i] = 0; fcw_m[i] = 0; ph0_m[i] = 0;
        end
        last_cos = 0; last_sin = 0;
        pipe.delete();
        repeat (3) pipe.push_back(idle);
    endtask

    task automatic do_reset(input bit dv_during);
        exp_t zero;
        zero = '{dv: 1'b0, chn: 0, cosv: 0, sinv: 0, sync: 1'b0};
        rst = 1'b1; din_dv = dv_during; din_chn = '0; sync_in = 1'b0; cfg_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; din_dv = 1'b0;
        model_reset();
        check_outputs(zero, 1'b0);
    endtask

    // One clock: model consumes the inputs, DUT is sampled 1 time unit after the edge.
    task automatic cycle(input bit dv, input int chn, input bit sync,
                         input bit we, input int cchn, input int cfcw, input int cph);
        exp_t e;
        int   phi;
        bit   err_exp;
        din_dv = dv; din_chn = CHN_WIDTH'(chn); sync_in = sync;
        cfg_we = we; cfg_chn = CHN_WIDTH'(cchn);
        cfg_fcw = PHASE_WIDTH'(cfcw); cfg_phase0 = PHASE_WIDTH'(cph);
        e.dv = dv; e.chn = chn; e.sync = sync; e.cosv = 0; e.sinv = 0;
        if (chn < NUM_CHN) begin
            phi    = (acc_m[chn] + ph0_m[chn]) % LUT_DEPTH;
            e.sinv = golden(phi);
            e.cosv = golden((phi + LUT_DEPTH / 4) % LUT_DEPTH);
        end
        pipe.push_back(e);
        if (sync) begin
            for (int i = 0; i < NUM_CHN; i++) acc_m[i] = 0;
        end else if (dv && chn < NUM_CHN) begin
            acc_m[chn] = (acc_m[chn] + fcw_m[chn]) % LUT_DEPTH;
        end
        err_exp = 1'b0;
        if (we) begin
            if (cchn < NUM_CHN && cfcw < LUT_DEPTH && cph < LUT_DEPTH) begin
                fcw_m[cchn] = cfcw; ph0_m[cchn] = cph;
            end else begin
                err_exp = 1'b1;
            end
        end
        @(posedge clk); #1;
        e = pipe.pop_front();
        if (e.dv) begin last_cos = e.cosv; last_sin = e.sinv; end
        check_outputs(e, err_exp);
    endtask

    task automatic sample(input int chn);
        cycle(1'b1, chn, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg(input int chn, input int f, input int p);
        cycle(1'b0, 0, 1'b0, 1'b1, chn, f, p);
    endtask

    initial begin
        // 1: single sample at phase 0
        do_reset(1'b0);
        do_reset(1'b0);
        cfg(0, 0, 0);
        idle(2);
        sample(0);
        idle(5);
        check("t1_cos_hold", 32'($signed(dout_cos)), 16384);
        check("t1_sin_hold", 32'($signed(dout_sin)), 0);

        // 2: fcw 419 wraps after 1257
        cfg(0, 419, 0);
        repeat (6) sample(0);
        idle(4);

        // 3: quarter-turn offset on chn 1, chn 0 interleaved
        cfg(1, 0, 384);
        sample(1); sample(0); sample(1); sample(1);
        idle(4);
        check("t3_sin_hold", 32'($signed(dout_sin)), 16384);
        check("t3_cos_hold", 32'($signed(dout_cos)), 0);

        // 4: four channels interleaved, fcw[2] rewritten mid-stream
        cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
        for (int c = 0; c < NUM_CHN; c++) cfg(c, c + 1, 0);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                if (r == 4 && c == 1) cycle(1'b1, c, 1'b0, 1'b1, 2, 37, 0);
                else                  sample(c);
            end
        end
        sample(3);
        idle(4);

        // 5: sync coincident with a sample at acc[0]=838
        cycle(1'b0, 0, 1'b1, 1'b1, 0, 419, 0);
        sample(0); sample(0);
        cycle(1'b1, 0, 1'b1, 1'b0, 0, 0, 0);
        sample(0);
        idle(5);
        check("t5_cos_hold", 32'($signed(dout_cos)), 16384);
        check("t5_sin_hold", 32'($signed(dout_sin)), 0);

        // 6: rejected config writes, out-of-range channel, same-cycle write+sample
        cfg(0, 1536, 0);
        cfg(5, 10, 10);
        cfg(0, 3, 1536);
        sample(0);
        cycle(1'b1, 0, 1'b0, 1'b1, 0, 100, 200);
        sample(0);
        sample(5);
        idle(4);
        check("t6_cos_oor", 32'($signed(dout_cos)), 0);
        check("t6_sin_oor", 32'($signed(dout_sin)), 0);

        // random traffic with occasional sync and (possibly invalid) config writes
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 1700)),
                  int'($urandom_range(0, 1700)));
        end

        // reset mid-stream drops in-flight samples
        sample(0); sample(1); sample(2);
        do_reset(1'b1);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
